// File: rtl/pf_req_queue.sv
// Prefetch request queue: FIFO between the L2 prefetcher and the request arbiter,
// merging requests for lines already queued and counting those merges.
module pf_req_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_BITS    = 21,
  parameter int unsigned SET_BITS    = 9,
  parameter int unsigned SOURCE_BITS = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       in_ready,
  input  logic                       in_valid,
  input  logic [TAG_BITS-1:0]        in_bits_tag,
  input  logic [SET_BITS-1:0]        in_bits_set,
  input  logic                       in_bits_needT,
  input  logic [SOURCE_BITS-1:0]     in_bits_source,
  input  logic                       in_bits_isBOP,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [TAG_BITS-1:0]        out_bits_tag,
  output logic [SET_BITS-1:0]        out_bits_set,
  output logic                       out_bits_needT,
  output logic [SOURCE_BITS-1:0]     out_bits_source,
  output logic                       out_bits_isBOP,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       perf_clean,
  output logic [15:0]                dup_cnt
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [TAG_BITS-1:0]    tag_q    [DEPTH];
  logic [SET_BITS-1:0]    set_q    [DEPTH];
  logic                   need_t_q [DEPTH];
  logic [SOURCE_BITS-1:0] source_q [DEPTH];
  logic                   is_bop_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [PTR_BITS-1:0]    head_q;
  logic [PTR_BITS-1:0]    tail_q;
  logic [CNT_BITS-1:0]    count_q;
  logic [15:0]            dup_q;

  logic                   full;
  logic                   accept;
  logic                   deq;
  logic                   hit;
  logic [PTR_BITS-1:0]    hit_idx;
  logic                   alloc;
  logic                   merge;

  assign full      = (count_q == CNT_BITS'(DEPTH));
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q[head_q];
  assign deq       = out_valid && out_ready;

  // The head leaving this cycle must not absorb a new request, or it would be lost.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && valid_q[i] && !(deq && (PTR_BITS'(i) == head_q)) &&
          (tag_q[i] == in_bits_tag) && (set_q[i] == in_bits_set)) begin
        hit     = 1'b1;
        hit_idx = PTR_BITS'(i);
      end
    end
  end

  assign alloc = accept && !hit;
  assign merge = accept && hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        set_q[i]    <= '0;
        need_t_q[i] <= 1'b0;
        source_q[i] <= '0;
        is_bop_q[i] <= 1'b0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_BITS'(1);
      end
      if (alloc) begin
        tag_q[tail_q]    <= in_bits_tag;
        set_q[tail_q]    <= in_bits_set;
        need_t_q[tail_q] <= in_bits_needT;
        source_q[tail_q] <= in_bits_source;
        is_bop_q[tail_q] <= in_bits_isBOP;
        valid_q[tail_q]  <= 1'b1;
        tail_q           <= tail_q + PTR_BITS'(1);
      end
      if (merge) begin
        need_t_q[hit_idx] <= need_t_q[hit_idx] | in_bits_needT;
      end
      count_q <= count_q + CNT_BITS'(alloc) - CNT_BITS'(deq);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dup_q <= '0;
    end else if (perf_clean) begin
      dup_q <= '0;
    end else if (merge && (dup_q != '1)) begin
      dup_q <= dup_q + 16'd1;
    end
  end

  assign out_bits_tag    = tag_q[head_q];
  assign out_bits_set    = set_q[head_q];
  assign out_bits_needT  = need_t_q[head_q];
  assign out_bits_source = source_q[head_q];
  assign out_bits_isBOP  = is_bop_q[head_q];
  assign count           = count_q;
  assign dup_cnt         = dup_q;

endmodule

// File: tb/tb_pf_req_queue.sv
// Directed bench for pf_req_queue: FIFO order, merge, head-dequeue race, flush,
// perf_clean priority and asynchronous reset.
module tb_pf_req_queue;

  logic        clock;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [20:0] in_bits_tag;
  logic [8:0]  in_bits_set;
  logic        in_bits_needT;
  logic [6:0]  in_bits_source;
  logic        in_bits_isBOP;
  logic        out_ready;
  logic        out_valid;
  logic [20:0] out_bits_tag;
  logic [8:0]  out_bits_set;
  logic        out_bits_needT;
  logic [6:0]  out_bits_source;
  logic        out_bits_isBOP;
  logic        flush;
  logic [2:0]  count;
  logic        perf_clean;
  logic [15:0] dup_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pf_req_queue #(
    .DEPTH(4),
    .TAG_BITS(21),
    .SET_BITS(9),
    .SOURCE_BITS(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_bits_tag(in_bits_tag),
    .in_bits_set(in_bits_set),
    .in_bits_needT(in_bits_needT),
    .in_bits_source(in_bits_source),
    .in_bits_isBOP(in_bits_isBOP),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bits_tag(out_bits_tag),
    .out_bits_set(out_bits_set),
    .out_bits_needT(out_bits_needT),
    .out_bits_source(out_bits_source),
    .out_bits_isBOP(out_bits_isBOP),
    .flush(flush),
    .count(count),
    .perf_clean(perf_clean),
    .dup_cnt(dup_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [20:0] t, input logic [8:0] s, input logic nt,
                      input logic [6:0] src, input logic bop);
    in_valid       = 1'b1;
    in_bits_tag    = t;
    in_bits_set    = s;
    in_bits_needT  = nt;
    in_bits_source = src;
    in_bits_isBOP  = bop;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [20:0] exp_tags [4];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bits_tag = '0; in_bits_set = '0;
    in_bits_needT = 1'b0; in_bits_source = '0; in_bits_isBOP = 1'b0;
    out_ready = 1'b0; flush = 1'b0; perf_clean = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_dup_cnt", dup_cnt, 0);
    check("rst_out_tag", out_bits_tag, 0);
    #9 reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single request, one-cycle latency
    @(negedge clock);
    push(21'h12345, 9'h1A, 1'b0, 7'd5, 1'b0);
    out_ready = 1'b1;
    check("single_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_tag", out_bits_tag, 32'h12345);
    check("single_set", out_bits_set, 32'h1A);
    check("single_needT", out_bits_needT, 0);
    check("single_source", out_bits_source, 5);
    check("single_count1", count, 1);
    tick();
    check("single_drained", out_valid, 0);
    check("single_count0", count, 0);

    // Fill with pointers starting at 1 so the order crosses the wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(21'h200 + 21'(i), 9'h10 + 9'(i), 1'b0, 7'(i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_head_tag", out_bits_tag, 32'h200);
    out_ready = 1'b1;
    push(21'h204, 9'h14, 1'b0, 7'd4, 1'b0);
    #1;
    check("full_no_passthru", in_ready, 0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("fill_after_deq_count", count, 3);
    check("fill_after_deq_ready", in_ready, 1);
    check("fill_after_deq_head", out_bits_tag, 32'h201);
    push(21'h204, 9'h14, 1'b0, 7'd4, 1'b0);
    tick();
    in_valid = 1'b0;
    check("refill_count", count, 4);
    exp_tags[0] = 21'h201; exp_tags[1] = 21'h202;
    exp_tags[2] = 21'h203; exp_tags[3] = 21'h204;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fifo_order_tag", out_bits_tag, 32'(exp_tags[i]));
      check("fifo_order_set", out_bits_set, 32'h11 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_count", count, 0);

    // Duplicate merge into the head entry
    push(21'h100, 9'd3, 1'b0, 7'd9, 1'b0);
    tick();
    push(21'h100, 9'd3, 1'b1, 7'h11, 1'b1);
    tick();
    in_valid = 1'b0;
    check("merge_count", count, 1);
    check("merge_needT", out_bits_needT, 1);
    check("merge_source_kept", out_bits_source, 9);
    check("merge_isBOP_kept", out_bits_isBOP, 0);
    check("merge_dup_cnt", dup_cnt, 1);

    // Same line arrives while its head entry dequeues: fresh allocation
    out_ready = 1'b1;
    push(21'h100, 9'd3, 1'b0, 7'h22, 1'b0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("race_count", count, 1);
    check("race_out_valid", out_valid, 1);
    check("race_source_new", out_bits_source, 32'h22);
    check("race_needT_new", out_bits_needT, 0);
    check("race_dup_unchanged", dup_cnt, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("race_drained", count, 0);

    // Flush with three queued and a request offered
    for (int i = 0; i < 3; i++) begin
      push(21'h300 + 21'(i), 9'd7, 1'b0, 7'd1, 1'b0);
      tick();
    end
    check("preflush_count", count, 3);
    push(21'h303, 9'd7, 1'b0, 7'd1, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_dup_kept", dup_cnt, 1);

    // perf_clean wins over a same-cycle merge
    push(21'h400, 9'd1, 1'b0, 7'd2, 1'b0);
    tick();
    push(21'h400, 9'd1, 1'b0, 7'd2, 1'b0);
    perf_clean = 1'b1;
    tick();
    perf_clean = 1'b0;
    check("clean_dup_cnt", dup_cnt, 0);
    check("clean_count", count, 1);
    push(21'h400, 9'd1, 1'b1, 7'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    check("post_clean_dup", dup_cnt, 1);
    check("post_clean_needT", out_bits_needT, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset between edges
    push(21'h500, 9'd2, 1'b0, 7'd3, 1'b0);
    tick();
    push(21'h501, 9'd2, 1'b0, 7'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("prereset_count", count, 2);
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_out_tag", out_bits_tag, 0);
    check("async_dup_cnt", dup_cnt, 0);
    #1 reset = 1'b1;
    push(21'h600, 9'd4, 1'b0, 7'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    check("after_reset_valid", out_valid, 1);
    check("after_reset_tag", out_bits_tag, 32'h600);
    check("after_reset_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
